prog_sequencer: RTL and testbench

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_seq_pkg.sv | 36 +++
 rtl/prog_sequencer_decoder.sv | 36 +++
 rtl/prog_sequencer.sv | 151 +++++++++++++++
 tb/tb_prog_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// Shared state, opcode and control-bundle definitions for the program sequencer.
// SEQ_BRANCH_EN adds the JMP/BRZ fields to the control bundle.
package prog_seq_pkg;

  localparam int OPW    = 3;
  localparam int ALUOPW = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam logic [OPW-1:0] OP_LOAD  = 3'b000;
  localparam logic [OPW-1:0] OP_STORE = 3'b001;
  localparam logic [OPW-1:0] OP_ALU   = 3'b010;
  localparam logic [OPW-1:0] OP_BRZ   = 3'b011;
  localparam logic [OPW-1:0] OP_JMP   = 3'b100;
  localparam logic [OPW-1:0] OP_HALT  = 3'b111;

  typedef struct packed {
    logic              dm_we;
    logic              dm_re;
    logic              rf_we;
    logic              load_sig;
    logic [ALUOPW-1:0] alu_op;
    logic              halt;
`ifdef SEQ_BRANCH_EN
    logic              jmp;
    logic              brz;
`endif
  } ctrl_t;

endpackage

// File: rtl/prog_sequencer_decoder.sv
// Combinational opcode decode of the instruction's top bits into the control bundle; zero latency.
// Opcodes 011/100 decode as branches only when SEQ_BRANCH_EN is defined, otherwise as NOP.
module seq_decoder
  import prog_seq_pkg::*;
(
  input  logic [OPW+ALUOPW-1:0] instr_i,
  output ctrl_t                 ctrl_o
);

  logic [OPW-1:0] op;

  assign op = instr_i[OPW+ALUOPW-1 -: OPW];

  always_comb begin
    ctrl_o = '0;
    case (op)
      OP_LOAD: begin
        ctrl_o.dm_re    = 1'b1;
        ctrl_o.rf_we    = 1'b1;
        ctrl_o.load_sig = 1'b1;
      end
      OP_STORE: ctrl_o.dm_we = 1'b1;
      OP_ALU: begin
        ctrl_o.rf_we  = 1'b1;
        ctrl_o.alu_op = instr_i[ALUOPW-1:0];
      end
`ifdef SEQ_BRANCH_EN
      OP_BRZ:  ctrl_o.brz = 1'b1;
      OP_JMP:  ctrl_o.jmp = 1'b1;
`endif
      OP_HALT: ctrl_o.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: loads words while isexternal is high, then fetches one instruction per advance and
// issues its controls for exactly one cycle. ld_ready is high only in LOAD. SEQ_BRANCH_EN enables JMP/BRZ.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter  int IW    = 12,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              isexternal,
  input  logic              ld_valid,
  input  logic [IW-1:0]     ld_data,
  output logic              ld_ready,
  input  logic              start,
  input  logic              mode_run,
  input  logic              nextinstruction,
  input  logic              zero_flag,
  output logic              DM_we,
  output logic              DM_re,
  output logic              RF_we,
  output logic              loadSignal,
  output logic [ALUOPW-1:0] ALU_op,
  output logic [AW-1:0]     pc_out,
  output logic [IW-1:0]     ir_out,
  output logic              halted,
  output logic              busy
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] mem [DEPTH];

  ctrl_t ctrl;
  logic  advance;
  logic  fetch;
  logic  halt_issue;
  logic  ld_we;

  seq_decoder u_dec (
    .instr_i (ir_q[IW-1 -: OPW+ALUOPW]),
    .ctrl_o  (ctrl)
  );

  // valid_q marks the single cycle in which the captured instruction issues
  assign halt_issue = valid_q & ctrl.halt;
  assign advance    = (state_q == ST_RUN) | ((state_q == ST_STEP) & nextinstruction);
  assign fetch      = advance & ~halt_issue;
  assign ld_we      = (state_q == ST_LOAD) & ld_valid;

`ifdef SEQ_BRANCH_EN
  logic branch_take;
  assign branch_take = valid_q & (ctrl.jmp | (ctrl.brz & zero_flag));
`else
  logic unused_zero_flag;
  assign unused_zero_flag = zero_flag;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (isexternal) state_d = ST_LOAD;
        else if (start) state_d = mode_run ? ST_RUN : ST_STEP;
      end
      ST_LOAD:          if (!isexternal) state_d = ST_IDLE;
      ST_RUN, ST_STEP:  if (halt_issue) state_d = ST_HALTED;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    wp_d    = wp_q;
    ir_d    = ir_q;
    valid_d = 1'b0;
    if (fetch) begin
      ir_d    = mem[pc_q];
      valid_d = 1'b1;
      pc_d    = pc_q + AW'(1);
    end
`ifdef SEQ_BRANCH_EN
    // Redirect wins over the sequential fetch, which becomes the bubble
    if (branch_take) begin
      pc_d    = ir_q[AW-1:0];
      valid_d = 1'b0;
    end
`endif
    if (ld_we) wp_d = wp_q + AW'(1);
    if ((state_q == ST_LOAD) && !isexternal) begin
      pc_d = '0;
      wp_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      wp_q    <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      wp_q    <= wp_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  // Program memory deliberately survives reset
  always_ff @(posedge clk) begin
    if (ld_we) mem[wp_q] <= ld_data;
  end

  always_comb begin
    ld_ready   = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    DM_we      = 1'b0;
    DM_re      = 1'b0;
    RF_we      = 1'b0;
    loadSignal = 1'b0;
    ALU_op     = '0;
    case (state_q)
      ST_LOAD:         ld_ready = 1'b1;
      ST_RUN, ST_STEP: busy     = 1'b1;
      ST_HALTED:       halted   = 1'b1;
      default: ;
    endcase
    if (valid_q) begin
      DM_we      = ctrl.dm_we;
      DM_re      = ctrl.dm_re;
      RF_we      = ctrl.rf_we;
      loadSignal = ctrl.load_sig;
      ALU_op     = ctrl.alu_op;
    end
  end

  assign pc_out = pc_q;
  assign ir_out = ir_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed load/run/step/branch/wrap/reset steps plus random programs,
// checked against a program-walking reference model.
module tb_prog_sequencer;

  localparam int IW    = 12;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int W     = 40;
`ifdef SEQ_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic isexternal = 1'b0, ld_valid = 1'b0, start = 1'b0, mode_run = 1'b0;
  logic nextinstruction = 1'b0, zero_flag = 1'b0;
  logic [IW-1:0] ld_data = '0;
  logic ld_ready, DM_we, DM_re, RF_we, loadSignal, halted, busy;
  logic [2:0]    ALU_op;
  logic [AW-1:0] pc_out;
  logic [IW-1:0] ir_out;

  int vectors = 0;
  int miscompares = 0;

  logic [IW-1:0] prog  [0:DEPTH-1];
  logic [IW-1:0] ldw   [0:15];
  logic [8:0]    got   [0:W];
  logic [8:0]    exp_v [0:W];
  logic [8:0]    ovec;

  assign ovec = {DM_we, DM_re, RF_we, loadSignal, ALU_op, halted, busy};

  prog_sequencer #(.IW(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .isexternal(isexternal),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .start(start), .mode_run(mode_run), .nextinstruction(nextinstruction),
    .zero_flag(zero_flag), .DM_we(DM_we), .DM_re(DM_re), .RF_we(RF_we),
    .loadSignal(loadSignal), .ALU_op(ALU_op), .pc_out(pc_out), .ir_out(ir_out),
    .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {DM_we, DM_re, RF_we, loadSignal, ALU_op} straight from the opcode table
  function automatic logic [6:0] ctrl_of(input logic [IW-1:0] w);
    logic [2:0] op;
    op = w[IW-1 -: 3];
    case (op)
      3'b000:  return 7'b0111000;
      3'b001:  return 7'b1000000;
      3'b010:  return {4'b0010, w[IW-4 -: 3]};
      default: return 7'b0000000;
    endcase
  endfunction

  // Cycles whose closing edge may fetch: every cycle in RUN, pulse cycles in STEP
  function automatic bit opp(input bit mrun, input int per, input int c);
    if (mrun) return c >= 1;
    return (c >= 3) && (((c - 3) % per) == 0);
  endfunction

  // Walks the program: each fetch issues on the next cycle; taken branch costs one bubble; HALT stops it
  task automatic build_model(input bit mrun, input int per, input bit zf, output int pc_end);
    int pc, cmin, c, t, halt_t;
    logic [IW-1:0] w;
    logic [2:0] op;
    bit taken;
    for (int k = 0; k <= W; k++) exp_v[k] = {7'b0, 1'b0, 1'(k >= 1)};
    pc = 0; cmin = 1; halt_t = W + 1;
    while (1) begin
      c = cmin;
      while (c < W && !opp(mrun, per, c)) c++;
      if (c >= W) break;
      t = c + 1;
      w = prog[pc];
      op = w[IW-1 -: 3];
      exp_v[t][8:2] = ctrl_of(w);
      if (op == 3'b111) begin
        halt_t = t;
        pc = (pc + 1) % DEPTH;
        break;
      end
      taken = BR_EN && (op == 3'b100 || (op == 3'b011 && zf));
      if (taken) begin
        pc = int'(w[AW-1:0]);
        cmin = t + 1;
      end else begin
        pc = (pc + 1) % DEPTH;
        cmin = t;
      end
    end
    for (int k = halt_t + 1; k <= W; k++) exp_v[k][1:0] = 2'b10;
    pc_end = pc;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  // Enters LOAD, streams n words, returns to IDLE, then offers stray words that must be ignored
  task automatic load_words(input int n);
    isexternal = 1'b1;
    @(negedge clk);
    chk("ld_ready_in_load", ld_ready, 1);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1; ld_data = ldw[i];
      @(negedge clk);
    end
    ld_valid = 1'b0; isexternal = 1'b0;
    @(negedge clk);
    chk("ld_ready_idle", ld_ready, 0);
    ld_valid = 1'b1; ld_data = '1;
    @(negedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) ldw[i] = prog[i];
    load_words(DEPTH);
  endtask

  task automatic run_trace(input bit mrun, input int per, input bit zf);
    start = 1'b1; mode_run = mrun; zero_flag = zf;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      start = 1'b0;
      got[k] = ovec;
      nextinstruction = !mrun && opp(1'b0, per, k);
    end
    nextinstruction = 1'b0;
  endtask

  task automatic compare_trace(input string tag);
    for (int k = 1; k <= W; k++)
      chk($sformatf("%s_c%0d", tag, k), got[k], exp_v[k]);
  endtask

  initial begin
    int pce, per;
    bit mrun, zf;
    logic [IW-1:0] r;
    logic [2:0] op;
    logic [IW-1:0] expmem [0:DEPTH-1];

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ctrl", ovec, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_ir", ir_out, 0);
    chk("rst_ld_ready", ld_ready, 0);
    reset = 1'b1;
    @(negedge clk);

    // Nine-word load wraps onto address 0; NOP program shows pc wrap 7,0,1
    for (int i = 0; i < 9; i++) begin
      r = IW'($urandom());
      ldw[i] = {($urandom_range(0, 1) != 0) ? 3'b101 : 3'b110, r[IW-4:0]};
    end
    load_words(9);
    expmem[0] = ldw[8];
    for (int i = 1; i < DEPTH; i++) expmem[i] = ldw[i];
    start = 1'b1; mode_run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("wrap_pc_c%0d", k), pc_out, (k - 1) % DEPTH);
      if (k >= 2) chk($sformatf("load_ir_c%0d", k), ir_out, expmem[(k - 2) % DEPTH]);
    end

    // Asynchronous reset mid-RUN clears outputs at once; memory survives
    reset = 1'b0;
    #1;
    chk("midrst_ctrl", ovec, 0);
    chk("midrst_pc", pc_out, 0);
    chk("midrst_ir", ir_out, 0);
    chk("midrst_ld_ready", ld_ready, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    start = 1'b1; mode_run = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k >= 2) chk($sformatf("restart_ir_c%0d", k), ir_out, expmem[k - 2]);
    end
    do_reset();

    // RUN: ALU op5, STORE, LOAD, HALT
    prog[0] = 12'b010_101_000000;
    prog[1] = 12'b001_000_000011;
    prog[2] = 12'b000_000_000101;
    prog[3] = 12'b111_000_000000;
    for (int i = 4; i < DEPTH; i++) prog[i] = 12'b101_000_000000;
    load_prog();
    run_trace(1'b1, 1, 1'b0);
    build_model(1'b1, 1, 1'b0, pce);
    compare_trace("run");
    chk("run_c2_rfwe", got[2][6], 1);
    chk("run_c2_aluop", got[2][4:2], 5);
    chk("run_c3_dmwe", got[3][8], 1);
    chk("run_c4_dmre", got[4][7], 1);
    chk("run_c4_loadsig", got[4][5], 1);
    chk("run_c5_halted", got[5][1], 0);
    chk("run_c6_halted", got[6][1], 1);

    // Restart from HALTED keeps pc
    chk("halted_pc", pc_out, pce);
    start = 1'b1; mode_run = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("rehalt_busy", busy, 1);
    chk("rehalt_halted", halted, 0);
    chk("rehalt_pc", pc_out, pce);
    do_reset();

    // STEP with pulses 10 cycles apart, program kept across reset
    run_trace(1'b0, 10, 1'b0);
    build_model(1'b0, 10, 1'b0, pce);
    compare_trace("step");
    do_reset();

    // BRZ at address 1 targeting 6
    prog[0] = 12'b101_000_000000;
    prog[1] = 12'b011_000_000110;
    prog[2] = 12'b010_001_000000;
    prog[3] = 12'b111_000_000000;
    prog[4] = 12'b111_000_000000;
    prog[5] = 12'b111_000_000000;
    prog[6] = 12'b010_110_000000;
    prog[7] = 12'b111_000_000000;
    load_prog();
    run_trace(1'b1, 1, 1'b1);
    build_model(1'b1, 1, 1'b1, pce);
    compare_trace("brz_taken");
    chk("brz_taken_c4_alu", got[4][4:2], BR_EN ? 3'd0 : 3'd1);
    chk("brz_taken_c5_alu", got[5][4:2], BR_EN ? 3'd6 : 3'd0);
    do_reset();
    run_trace(1'b1, 1, 1'b0);
    build_model(1'b1, 1, 1'b0, pce);
    compare_trace("brz_nottaken");
    chk("brz_nottaken_c4_alu", got[4][4:2], 1);
    do_reset();

    // Random programs in random modes
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        r = IW'($urandom());
        case ($urandom_range(0, 9))
          0: op = 3'b000;
          1: op = 3'b001;
          2, 3, 9: op = 3'b010;
          4: op = 3'b011;
          5: op = 3'b100;
          6: op = 3'b101;
          7: op = 3'b110;
          default: op = 3'b111;
        endcase
        prog[i] = {op, r[IW-4:0]};
      end
      mrun = ($urandom_range(0, 1) != 0);
      zf   = ($urandom_range(0, 1) != 0);
      per  = $urandom_range(1, 5);
      load_prog();
      run_trace(mrun, per, zf);
      build_model(mrun, per, zf, pce);
      compare_trace($sformatf("rand%0d", it));
      do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
